// File: rtl/fp_pkg.sv
// Shared definitions for the parameterised floating-point multiplier.
// Provides the controller state enum, bit positions of the four status flags
// and helpers that derive the exponent bias and the canonical quiet NaN from
// the field widths.
// Ports: none (package).
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    MULTIPLY,
    NORMALIZE,
    ROUND,
    DONE
  } state_t;

  // Flag vector packing is {invalid, overflow, underflow, inexact}.
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // Exponent bias for an exp_w-bit exponent field.
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
  // Returned 64 bits wide; callers truncate to their operand width.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      r[i] = (i == man_w - 1) || ((i >= man_w) && (i < man_w + exp_w));
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_multiplier_param_round.sv
// Round-to-nearest, ties-to-even on a stored mantissa.
// Ports:
//   man      - mantissa bits kept in the result (hidden bit excluded)
//   guard    - first discarded bit
//   round    - second discarded bit
//   sticky   - OR of every remaining discarded bit
//   man_out  - rounded mantissa
//   carry    - rounding overflowed the mantissa (caller renormalises)
//   inexact  - some discarded bit was nonzero
module fp_round_rne #(
  parameter int MAN_W = 23
) (
  input  logic [MAN_W-1:0] man,
  input  logic             guard,
  input  logic             round,
  input  logic             sticky,
  output logic [MAN_W-1:0] man_out,
  output logic             carry,
  output logic             inexact
);

  localparam int MW1 = MAN_W + 1;

  logic round_up;

  // Round up when above halfway, or exactly halfway with an odd LSB so that
  // ties land on the even neighbour.
  assign round_up = guard & (round | sticky | man[0]);
  assign {carry, man_out} = {1'b0, man} + MW1'(round_up);
  assign inexact = guard | round | sticky;

endmodule

// File: rtl/fp_multiplier_param.sv
// Multi-cycle IEEE-754 style multiplier with parameterised field widths.
// One operation at a time: accept, unpack, multiply, normalise, round, then
// hold the result until the consumer takes it. Subnormal inputs are read as
// zero and underflowing results are flushed to zero.
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   in_valid / in_ready - operand handshake (ready only while idle)
//   a, b                - operands packed {sign, exp, man}
//   out_valid/out_ready - result handshake
//   product             - rounded product, same packing
//   flags               - {invalid, overflow, underflow, inexact}
module fp_multiplier_param
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   product,
  output logic [3:0]             flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int PW  = 2 * MAN_W + 2;
  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] BIAS    = EW2'(fp_bias(EXP_W));
  localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] EXP_ZERO = '0;
  localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));

  state_t state, state_next;

  logic [W-1:0]              a_reg, b_reg;
  logic                      sign_r;
  logic signed [EW2-1:0]     exp_r;
  logic [MAN_W:0]            man_a_r, man_b_r;
  logic                      special_r;
  logic [W-1:0]              special_prod_r;
  logic [3:0]                special_flags_r;
  logic [PW-1:0]             prod_r;
  logic [2*MAN_W-1:0]        norm_r;
  logic                      extra_r;

  // State register: reset wins over any handshake seen at the same edge.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: only IDLE and DONE wait on a handshake; the four
  // processing stages advance every cycle regardless of operand class.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (in_valid) state_next = UNPACK;
      UNPACK:    state_next = MULTIPLY;
      MULTIPLY:  state_next = NORMALIZE;
      NORMALIZE: state_next = ROUND;
      ROUND:     state_next = DONE;
      DONE:      if (out_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand classification. Special results are decided up front and carried
  // alongside the normal datapath so every operand class takes the same time.
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_snan, b_snan, sign_u;
  logic             spec_hit;
  logic [W-1:0]     spec_prod;
  logic [3:0]       spec_flags;

  always_comb begin
    ea = a_reg[W-2:MAN_W];
    eb = b_reg[W-2:MAN_W];
    ma = a_reg[MAN_W-1:0];
    mb = b_reg[MAN_W-1:0];
    a_nan  = (&ea) && (|ma);
    b_nan  = (&eb) && (|mb);
    a_inf  = (&ea) && !(|ma);
    b_inf  = (&eb) && !(|mb);
    a_zero = ~|ea;
    b_zero = ~|eb;
    a_snan = a_nan && !ma[MAN_W-1];
    b_snan = b_nan && !mb[MAN_W-1];
    sign_u = a_reg[W-1] ^ b_reg[W-1];
    spec_hit   = 1'b1;
    spec_prod  = '0;
    spec_flags = '0;
    if (a_nan || b_nan) begin
      spec_prod = QNAN;
      spec_flags[FLAG_INVALID] = a_snan || b_snan;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      spec_prod = QNAN;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_prod = {sign_u, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      spec_prod = {sign_u, {W-1{1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Normalisation: the product of two [1,2) significands lies in [1,4); when
  // it reaches 2 shift right once, keeping the dropped bit for sticky.
  logic [2*MAN_W-1:0]    norm_next;
  logic                  extra_next;
  logic signed [EW2-1:0] exp_norm;

  always_comb begin
    norm_next  = prod_r[2*MAN_W-1:0];
    extra_next = 1'b0;
    exp_norm   = exp_r;
    if (prod_r[PW-1]) begin
      norm_next  = prod_r[2*MAN_W:1];
      extra_next = prod_r[0];
      exp_norm   = exp_r + EW2'(1);
    end
  end

  // Rounding: upper half of the normalised fraction is kept, the lower half
  // supplies guard, round and sticky.
  logic [MAN_W-1:0] low_bits, tail_bits, man_round;
  logic             guard, round_bit, sticky, carry, inexact;

  always_comb begin
    low_bits  = norm_r[MAN_W-1:0];
    tail_bits = low_bits << 2;
    guard     = low_bits[MAN_W-1];
    round_bit = low_bits[MAN_W-2];
    sticky    = (|tail_bits) | extra_r;
  end

  fp_round_rne #(.MAN_W(MAN_W)) u_round (
    .man     (norm_r[2*MAN_W-1:MAN_W]),
    .guard   (guard),
    .round   (round_bit),
    .sticky  (sticky),
    .man_out (man_round),
    .carry   (carry),
    .inexact (inexact)
  );

  // Final result selection: a rounding carry leaves man_round at zero, so
  // bumping the exponent is all the renormalisation needed.
  logic signed [EW2-1:0] final_e;
  logic [W-1:0]          round_prod;
  logic [3:0]            round_flags;

  always_comb begin
    final_e     = exp_r + (carry ? EW2'(1) : EW2'(0));
    round_prod  = {sign_r, final_e[EXP_W-1:0], man_round};
    round_flags = '0;
    round_flags[FLAG_INEXACT] = inexact;
    if (special_r) begin
      round_prod  = special_prod_r;
      round_flags = special_flags_r;
    end else if (final_e >= EXP_MAX) begin
      round_prod  = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      round_flags = '0;
      round_flags[FLAG_OVERFLOW] = 1'b1;
      round_flags[FLAG_INEXACT]  = 1'b1;
    end else if (final_e <= EXP_ZERO) begin
      round_prod  = {sign_r, {W-1{1'b0}}};
      round_flags = '0;
      round_flags[FLAG_UNDERFLOW] = 1'b1;
      round_flags[FLAG_INEXACT]   = 1'b1;
    end
  end

  // Datapath registers: each stage loads its own registers while the
  // controller sits in that stage; the result is held through DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg           <= '0;
      b_reg           <= '0;
      sign_r          <= 1'b0;
      exp_r           <= '0;
      man_a_r         <= '0;
      man_b_r         <= '0;
      special_r       <= 1'b0;
      special_prod_r  <= '0;
      special_flags_r <= '0;
      prod_r          <= '0;
      norm_r          <= '0;
      extra_r         <= 1'b0;
      product         <= '0;
      flags           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
          end
        end
        UNPACK: begin
          sign_r          <= sign_u;
          exp_r           <= {2'b00, ea} + {2'b00, eb} - BIAS;
          man_a_r         <= {1'b1, ma};
          man_b_r         <= {1'b1, mb};
          special_r       <= spec_hit;
          special_prod_r  <= spec_prod;
          special_flags_r <= spec_flags;
        end
        MULTIPLY: begin
          prod_r <= PW'(man_a_r) * PW'(man_b_r);
        end
        NORMALIZE: begin
          norm_r  <= norm_next;
          extra_r <= extra_next;
          exp_r   <= exp_norm;
        end
        ROUND: begin
          product <= round_prod;
          flags   <= round_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_multiplier_param.sv
// Self-checking bench for fp_multiplier_param: one binary32 instance and one
// binary16-style instance (EXP_W=5, MAN_W=10) share the clock and reset.
// Expected results come from an integer reference model working on whole
// significand products and remainders.
module tb_fp_multiplier_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] a32, b32, product32;
  logic [3:0]  flags32;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, product16;
  logic [3:0]  flags16;

  int checks = 0;
  int errors = 0;

  fp_multiplier_param #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid32), .in_ready(in_ready32), .a(a32), .b(b32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .product(product32), .flags(flags32)
  );

  fp_multiplier_param #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .product(product16), .flags(flags16)
  );

  // Reference multiply with DAZ/FTZ and round-to-nearest-even via remainder.
  function automatic void model_mul(input longint unsigned op_a, input longint unsigned op_b,
                                    input int ew, input int mw,
                                    output longint unsigned res, output logic [3:0] flg);
    longint unsigned mask_m, maxe, sa, sb, ea, eb, ma, mb, sign, p, q, rem, half;
    int bias, e, s;
    bit a_nan, b_nan, inexact;
    mask_m = (64'd1 << mw) - 1;
    maxe   = (64'd1 << ew) - 1;
    bias   = (1 << (ew - 1)) - 1;
    sa = (op_a >> (ew + mw)) & 1;
    sb = (op_b >> (ew + mw)) & 1;
    ea = (op_a >> mw) & maxe;
    eb = (op_b >> mw) & maxe;
    ma = op_a & mask_m;
    mb = op_b & mask_m;
    sign = sa ^ sb;
    a_nan = (ea == maxe) && (ma != 0);
    b_nan = (eb == maxe) && (mb != 0);
    flg = 4'b0000;
    if (a_nan || b_nan) begin
      res = (maxe << mw) | (64'd1 << (mw - 1));
      flg[3] = (a_nan && ((ma >> (mw - 1)) & 1) == 0) || (b_nan && ((mb >> (mw - 1)) & 1) == 0);
    end else if ((ea == maxe && eb == 0) || (ea == 0 && eb == maxe)) begin
      res = (maxe << mw) | (64'd1 << (mw - 1));
      flg = 4'b1000;
    end else if (ea == maxe || eb == maxe) begin
      res = (sign << (ew + mw)) | (maxe << mw);
    end else if (ea == 0 || eb == 0) begin
      res = sign << (ew + mw);
    end else begin
      e = int'(ea) + int'(eb) - bias;
      p = (ma | (64'd1 << mw)) * (mb | (64'd1 << mw));
      if (p >= (64'd1 << (2 * mw + 1))) begin
        s = mw + 1;
        e++;
      end else begin
        s = mw;
      end
      q    = p >> s;
      rem  = p & ((64'd1 << s) - 1);
      half = 64'd1 << (s - 1);
      inexact = (rem != 0);
      if (rem > half || (rem == half && (q & 1) == 1)) q++;
      if (q == (64'd1 << (mw + 1))) begin
        q = q >> 1;
        e++;
      end
      if (e >= int'(maxe)) begin
        res = (sign << (ew + mw)) | (maxe << mw);
        flg = 4'b0101;
      end else if (e <= 0) begin
        res = sign << (ew + mw);
        flg = 4'b0011;
      end else begin
        res = (sign << (ew + mw)) | (longint'(e) << mw) | (q & mask_m);
        flg = {3'b000, inexact};
      end
    end
  endfunction

  // Random operand biased towards interesting classes and exponent edges.
  function automatic longint unsigned rand_operand(input int ew, input int mw);
    longint unsigned mask_m, maxe, man, ex, sg;
    int bias, sel;
    mask_m = (64'd1 << mw) - 1;
    maxe   = (64'd1 << ew) - 1;
    bias   = (1 << (ew - 1)) - 1;
    sel    = int'($urandom_range(0, 11));
    man    = {32'($urandom), 32'($urandom)} & mask_m;
    sg     = longint'($urandom_range(0, 1));
    case (sel)
      0:       begin ex = 0; man = 0; end
      1:       ex = 0;
      2:       begin ex = maxe; man = 0; end
      3:       begin ex = maxe; man = man | 1; end
      4:       ex = maxe - 1 - longint'($urandom_range(0, 3));
      5:       ex = 1 + longint'($urandom_range(0, 3));
      default: ex = longint'(bias - 10 + int'($urandom_range(0, 20)));
    endcase
    return (sg << (ew + mw)) | (ex << mw) | man;
  endfunction

  // Drives one operation into the selected instance, measures the edges from
  // acceptance to out_valid (bounded), captures the result and releases it.
  task automatic do_op(input bit sel, input longint unsigned op_a, input longint unsigned op_b,
                       output longint unsigned res, output logic [3:0] flg, output int lat);
    if (sel) begin
      a16 = op_a[15:0]; b16 = op_b[15:0]; in_valid16 = 1'b1;
    end else begin
      a32 = op_a[31:0]; b32 = op_b[31:0]; in_valid32 = 1'b1;
    end
    @(posedge clock); #1;
    in_valid16 = 1'b0;
    in_valid32 = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clock); #1;
      lat++;
      if (sel ? out_valid16 : out_valid32) break;
    end
    res = sel ? {48'd0, product16} : {32'd0, product32};
    flg = sel ? flags16 : flags32;
    if (sel) out_ready16 = 1'b1; else out_ready32 = 1'b1;
    @(posedge clock); #1;
    out_ready16 = 1'b0;
    out_ready32 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    checks += 6;
    if (in_ready32 !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready32 got %b want 1", in_ready32); end
    if (out_valid32 !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid32 got %b want 0", out_valid32); end
    if (product32 !== 32'h0) begin errors++; $display("[TB] FAIL reset_product32 got %h want 0", product32); end
    if (flags32 !== 4'h0) begin errors++; $display("[TB] FAIL reset_flags32 got %b want 0", flags32); end
    if (in_ready16 !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready16 got %b want 1", in_ready16); end
    if (out_valid16 !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid16 got %b want 0", out_valid16); end
  endtask

  task automatic test_directed;
    logic [31:0] va [10] = '{32'h3FC00000, 32'h7F800000, 32'hFF800000, 32'h7F7FFFFF, 32'h00800000,
                             32'h3F800001, 32'h7F800001, 32'h7FC00001, 32'h80000000, 32'h00000001};
    logic [31:0] vb [10] = '{32'h40000000, 32'h00000000, 32'h40000000, 32'h40000000, 32'h00800000,
                             32'h3F800001, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F000000};
    logic [31:0] vp [10] = '{32'h40400000, 32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h00000000,
                             32'h3F800002, 32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'h00000000};
    logic [3:0]  vf [10] = '{4'b0000, 4'b1000, 4'b0000, 4'b0101, 4'b0011,
                             4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    longint unsigned res;
    logic [3:0] flg;
    int lat;
    for (int i = 0; i < 10; i++) begin
      do_op(1'b0, longint'(va[i]), longint'(vb[i]), res, flg, lat);
      checks += 3;
      if (lat !== 4) begin errors++; $display("[TB] FAIL directed%0d_latency got %0d want 4", i, lat); end
      if (res[31:0] !== vp[i]) begin errors++; $display("[TB] FAIL directed%0d_product got %h want %h", i, res[31:0], vp[i]); end
      if (flg !== vf[i]) begin errors++; $display("[TB] FAIL directed%0d_flags got %b want %b", i, flg, vf[i]); end
    end
  endtask

  task automatic test_fp16;
    longint unsigned res;
    logic [3:0] flg;
    int lat;
    do_op(1'b1, 64'h3C00, 64'hC000, res, flg, lat);
    checks += 3;
    if (lat !== 4) begin errors++; $display("[TB] FAIL fp16_latency got %0d want 4", lat); end
    if (res[15:0] !== 16'hC000) begin errors++; $display("[TB] FAIL fp16_product got %h want c000", res[15:0]); end
    if (flg !== 4'b0000) begin errors++; $display("[TB] FAIL fp16_flags got %b want 0000", flg); end
  endtask

  task automatic test_random;
    longint unsigned op_a, op_b, res, exp_res;
    logic [3:0] flg, exp_flg;
    int lat;
    for (int i = 0; i < 250; i++) begin
      bit sel;
      int ew, mw;
      sel = (i >= 150);
      ew = sel ? 5 : 8;
      mw = sel ? 10 : 23;
      op_a = rand_operand(ew, mw);
      op_b = rand_operand(ew, mw);
      model_mul(op_a, op_b, ew, mw, exp_res, exp_flg);
      do_op(sel, op_a, op_b, res, flg, lat);
      checks += 3;
      if (lat !== 4) begin errors++; $display("[TB] FAIL random%0d_latency got %0d want 4", i, lat); end
      if (res !== exp_res) begin errors++; $display("[TB] FAIL random%0d_product a=%h b=%h got %h want %h", i, op_a, op_b, res, exp_res); end
      if (flg !== exp_flg) begin errors++; $display("[TB] FAIL random%0d_flags a=%h b=%h got %b want %b", i, op_a, op_b, flg, exp_flg); end
    end
  endtask

  task automatic test_backpressure;
    int n;
    a32 = 32'h3FC00000; b32 = 32'h40000000; in_valid32 = 1'b1;
    @(posedge clock); #1;
    in_valid32 = 1'b0;
    n = 0;
    while (n < 20 && !out_valid32) begin @(posedge clock); #1; n++; end
    checks++;
    if (n !== 4) begin errors++; $display("[TB] FAIL bp_latency got %0d want 4", n); end
    // Offer different operands while the result is stalled; they must be ignored.
    a32 = 32'h40400000; b32 = 32'h40400000; in_valid32 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      checks += 4;
      if (out_valid32 !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid c%0d got %b want 1", c, out_valid32); end
      if (in_ready32 !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready c%0d got %b want 0", c, in_ready32); end
      if (product32 !== 32'h40400000) begin errors++; $display("[TB] FAIL bp_product c%0d got %h want 40400000", c, product32); end
      if (flags32 !== 4'b0000) begin errors++; $display("[TB] FAIL bp_flags c%0d got %b want 0000", c, flags32); end
    end
    out_ready32 = 1'b1;
    @(posedge clock); #1;
    out_ready32 = 1'b0;
    in_valid32 = 1'b0;
    checks += 2;
    if (out_valid32 !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_out_valid got %b want 0", out_valid32); end
    if (in_ready32 !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_in_ready got %b want 1", in_ready32); end
    n = 0;
    for (int c = 0; c < 6; c++) begin @(posedge clock); #1; if (out_valid32) n++; end
    checks++;
    if (n !== 0) begin errors++; $display("[TB] FAIL bp_no_spurious_op got %0d valid cycles want 0", n); end
  endtask

  task automatic test_reset_midop;
    int n;
    a32 = 32'h40400000; b32 = 32'h40400000; in_valid32 = 1'b1;
    @(posedge clock); #1;
    in_valid32 = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks += 4;
    if (in_ready32 !== 1'b1) begin errors++; $display("[TB] FAIL midreset_in_ready got %b want 1", in_ready32); end
    if (out_valid32 !== 1'b0) begin errors++; $display("[TB] FAIL midreset_out_valid got %b want 0", out_valid32); end
    if (product32 !== 32'h0) begin errors++; $display("[TB] FAIL midreset_product got %h want 0", product32); end
    if (flags32 !== 4'h0) begin errors++; $display("[TB] FAIL midreset_flags got %b want 0", flags32); end
    n = 0;
    for (int c = 0; c < 8; c++) begin @(posedge clock); #1; if (out_valid32) n++; end
    checks++;
    if (n !== 0) begin errors++; $display("[TB] FAIL midreset_out_valid_rose got %0d cycles want 0", n); end
  endtask

  task automatic test_back_to_back;
    int n;
    out_ready32 = 1'b1;
    a32 = 32'h3FC00000; b32 = 32'h40000000; in_valid32 = 1'b1;
    @(posedge clock); #1;
    // Operands change right after acceptance; in_valid stays high throughout.
    a32 = 32'h40400000; b32 = 32'hC0000000;
    n = 0;
    while (n < 20) begin @(posedge clock); #1; n++; if (out_valid32) break; end
    checks += 2;
    if (n !== 4) begin errors++; $display("[TB] FAIL b2b_first_latency got %0d want 4", n); end
    if (product32 !== 32'h40400000) begin errors++; $display("[TB] FAIL b2b_first_product got %h want 40400000", product32); end
    n = 0;
    while (n < 20) begin @(posedge clock); #1; n++; if (out_valid32) break; end
    in_valid32 = 1'b0;
    checks += 3;
    if (n !== 6) begin errors++; $display("[TB] FAIL b2b_gap got %0d want 6", n); end
    if (product32 !== 32'hC0C00000) begin errors++; $display("[TB] FAIL b2b_second_product got %h want c0c00000", product32); end
    if (flags32 !== 4'b0000) begin errors++; $display("[TB] FAIL b2b_second_flags got %b want 0000", flags32); end
    @(posedge clock); #1;
    out_ready32 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid32 = 1'b0; out_ready32 = 1'b0; a32 = '0; b32 = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0;
    test_reset();
    test_directed();
    test_fp16();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before the test sequence finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/fp_multiplier_param.md
FP_MULTIPLIER_PARAM -- requirements
Module: fp_multiplier_param

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (3..11).
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa width (2..52); operand width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands a, b valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  W  multiplicand, IEEE-754 style packing {sign, exp, man}.
REQ-008 SHALL have port b  input  W  multiplier, same packing.
REQ-009 SHALL have port out_valid  output  1  product and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port product  output  W  rounded product.
REQ-012 SHALL have port flags  output  4  {invalid, overflow, underflow, inexact}.

Function
REQ-013 SHALL use FSM states IDLE, UNPACK, MULTIPLY, NORMALIZE, ROUND, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 SHALL accept operands on in_valid && in_ready, registering a and b and moving to UNPACK.
REQ-015 SHALL advance UNPACK->MULTIPLY->NORMALIZE->ROUND->DONE one state per cycle, unconditionally; out_valid rises exactly 4 edges after the accepting edge, for every operand class, special cases included.
REQ-016 SHALL hold product, flags and out_valid stable in DONE until out_ready is high; on out_valid && out_ready, go to IDLE (next accept no earlier than the following edge).
REQ-017 SHALL ignore in_valid outside IDLE; a and b may change freely after acceptance.
REQ-018 SHALL compute sign = sign_a XOR sign_b for all non-NaN results.
REQ-019 SHALL use bias = 2^(EXP_W-1)-1 and exponent arithmetic of signed width EXP_W+2: e = ea + eb - bias.
REQ-020 SHALL form a full (2*MAN_W+2)-bit product of {1,man_a} x {1,man_b}; if MSB is set, shift right 1 and increment e.
REQ-021 SHALL round to nearest, ties to even, using guard, round and sticky (OR of all lower bits); a rounding carry out of the mantissa SHALL renormalise (mantissa 0, e+1).
REQ-022 SHALL set inexact when any discarded bit is nonzero.
REQ-023 SHALL treat inputs with exponent 0 (zero or subnormal) as signed zero (denormals-are-zero).
REQ-024 SHALL, for either input NaN, or infinity x zero, output canonical qNaN {0, all-ones exp, man MSB=1, rest 0}; invalid set only for infinity x zero or a signalling NaN input (man MSB=0).
REQ-025 SHALL, for infinity x finite nonzero, output signed infinity with flags 0.
REQ-026 SHALL, for zero x finite, output signed zero with flags 0.
REQ-027 SHALL, if final e >= 2^EXP_W-1, output signed infinity and set overflow and inexact.
REQ-028 SHALL, if final e <= 0 for a nonzero product, output signed zero (flush to zero) and set underflow and inexact.

Reset
REQ-029 SHALL, when reset is high at an edge, go to IDLE and clear product, flags and all datapath registers to 0 (out_valid=0, in_ready=1 on the next cycle), aborting any operation in progress.
REQ-030 SHALL give reset priority over every handshake at the same edge.

Structure
REQ-031 SHALL import from package fp_pkg: state enum, flag-index constants, and functions for bias and canonical qNaN as functions of EXP_W/MAN_W.
REQ-032 SHALL isolate RNE rounding in sub-module fp_round_rne (mantissa+GRS in; rounded mantissa, carry and inexact out).

Verification
REQ-033 SHALL check 0x3FC00000 x 0x40000000 -> 0x40000000 scaled: product 0x40400000, flags 0, out_valid 4 edges after accept.
REQ-034 SHALL check 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1; 0xFF800000 x 0x40000000 -> 0xFF800000, flags 0.
REQ-035 SHALL check 0x7F7FFFFF x 0x40000000 -> 0x7F800000, overflow=1, inexact=1; 0x00800000 x 0x00800000 -> 0x00000000, underflow=1, inexact=1.
REQ-036 SHALL check 0x3F800001 x 0x3F800001 -> 0x3F800002, inexact=1 (RNE).
REQ-037 SHALL check backpressure and reset: out_ready low 3 cycles keeps product, flags stable and in_ready=0; reset asserted in MULTIPLY -> IDLE, out_valid never rises.
REQ-038 SHALL check EXP_W=5, MAN_W=10: 0x3C00 x 0xC000 -> 0xC000, flags 0.
